hazard_fwd_ctrl: RTL and testbench
==================================

HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 Parameter NUM_FWD, default 2, number of post-EX stages that can forward (stage 1 = MEM, stage NUM_FWD = WB); legal range 1..4.
REQ-002 Parameter DIV_LAT, default 33, cycles the multi-cycle divider occupies EX; legal range 2..64.
REQ-003 Parameter RA_W, default 5, register address width.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_mem_to_reg, id_mem_acc, id_branch, id_is_div  in  1 each  ID-stage decode attributes.
REQ-007 id_rs1_addr, id_rs2_addr, id_rd_addr  in  RA_W each  ID-stage register addresses.
REQ-008 branch_taken  in  1  branch comparator result, evaluated in ID.
REQ-009 dmem_ready  in  1  data memory completes the MEM-stage access this cycle.
REQ-010 pc_en, if_id_en  out  1  PC and IF/ID register enables.
REQ-011 id_ex_bubble  out  1  insert NOP into ID/EX.
REQ-012 if_id_flush  out  1  clear IF/ID.
REQ-013 fwd_a, fwd_b  out  clog2(NUM_FWD+1)  EX operand source: 0 = register file, k = stage k.
REQ-014 br_fwd_a, br_fwd_b  out  1  ID branch operand taken from MEM stage.
REQ-015 div_start  out  1  one-cycle divider launch pulse; div_busy  out  1  divider occupying EX.

Function
REQ-016 Tracked state: an EX entry {valid, rs1, rs2, rd, rd_we, mem_to_reg, mem_acc, is_div} and NUM_FWD downstream entries {valid, rd, rd_we, mem_to_reg, mem_acc}; all shift one stage per cycle unless frozen.
REQ-017 freeze = div_busy OR (MEM entry valid AND mem_acc AND NOT dmem_ready); while frozen, no tracked entry changes and pc_en = if_id_en = 0.
REQ-018 Load-use stall: EX valid, mem_to_reg, rd != 0, and rd equals a used ID source -> pc_en = if_id_en = 0, id_ex_bubble = 1.
REQ-019 Branch stall: id_branch and a used ID source equals EX rd (rd_we, rd != 0), or equals MEM rd with MEM mem_to_reg -> same outputs as REQ-018.
REQ-020 Priority: freeze > stall > flush; if_id_flush = id_valid AND id_branch AND branch_taken AND NOT freeze AND NOT stall.
REQ-021 fwd_a: smallest k such that stage k valid, rd_we, rd != 0, and rd == EX rs1; 0 if none; fwd_b likewise for rs2; register 0 is never forwarded.
REQ-022 br_fwd_a/b = MEM valid, rd_we, NOT mem_to_reg, rd != 0, rd == ID rs1/rs2; WB-to-ID is covered by the write-first register file.
REQ-023 Divider FSM states IDLE, BUSY. IDLE->BUSY when EX entry valid AND is_div AND NOT freeze-by-memory: div_start = 1 that cycle, counter loaded with DIV_LAT-1.
REQ-024 In BUSY, div_busy = 1 and the counter decrements each cycle; at counter 0 go to IDLE with div_busy = 0 that cycle, so the divide leaves EX on the following edge; total EX occupancy is DIV_LAT cycles.
REQ-025 A memory stall during BUSY does not pause the counter; a divide whose count reaches 0 while memory is still stalled remains in EX until the memory stall clears.
REQ-026 Stall or bubble writes an invalid entry into EX; flush clears only IF/ID, so the EX entry is unaffected.
REQ-027 All outputs are combinational from tracked state and ID inputs; there is no added latency.

Reset
REQ-028 While rst_n = 0 at an edge: all entries are invalid, FSM is IDLE, counter = 0.
REQ-029 Output values during and immediately after reset: pc_en = if_id_en = 1, all other outputs 0.
REQ-030 Reset asserted mid-divide or mid-memory-stall abandons the operation with no residual stall.

Structure
REQ-031 Shared package holds the stage-entry struct, fwd-select encoding constants, and the FSM state enum.
REQ-032 One sub-module, div_occupancy_fsm, implements REQ-023..025.

Verification
REQ-033 EX: add x5; ID: sub using x5 -> fwd_a = 1 next cycle, no stall.
REQ-034 Load to x7 in EX, ID uses x7 -> exactly 1 cycle with pc_en = 0 and id_ex_bubble = 1; then fwd = 2 with NUM_FWD = 2.
REQ-035 Divide with DIV_LAT = 33 -> div_start for 1 cycle, div_busy for 33 cycles, pc_en = 0 throughout; a dmem_ready = 0 pulse during the divide does not extend it.
REQ-036 Taken branch with no hazard -> if_id_flush = 1 for 1 cycle; taken branch with a dmem stall active -> flush is withheld until the stall clears.
REQ-037 Writes to x0 in MEM and WB with EX reading x0 -> fwd_a = fwd_b = 0.
REQ-038 rst_n = 0 mid-divide -> next cycle div_busy = 0, pc_en = 1.

Source files
------------

// File: rtl/hazard_fwd_ctrl_pkg.sv
// hazard_fwd_ctrl_pkg: shared stage-entry types, forward-select codes and divider states.
// Register addresses are zero-extended to RA_MAX bits inside the tracked entries.
package hazard_fwd_ctrl_pkg;

   localparam int RA_MAX  = 8;
   localparam int FWD_RF  = 0;
   localparam int FWD_MEM = 1;

   typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_t;

   typedef struct packed {
      logic              valid;
      logic [RA_MAX-1:0] rs1;
      logic [RA_MAX-1:0] rs2;
      logic [RA_MAX-1:0] rd;
      logic              rd_we;
      logic              mem_to_reg;
      logic              mem_acc;
      logic              is_div;
   } ex_entry_t;

   typedef struct packed {
      logic              valid;
      logic [RA_MAX-1:0] rd;
      logic              rd_we;
      logic              mem_to_reg;
      logic              mem_acc;
   } dn_entry_t;

   function automatic logic writes(dn_entry_t e, logic [RA_MAX-1:0] a);
      return e.valid && e.rd_we && e.rd != '0 && e.rd == a;
   endfunction

endpackage

// File: rtl/div_occupancy_fsm.sv
// div_occupancy_fsm: holds a divide in EX for DIV_LAT frozen cycles, counting through memory
// stalls; a finished divide waits in BUSY at count 0 until memory lets the pipeline move.
module div_occupancy_fsm
   import hazard_fwd_ctrl_pkg::*;
#(
   parameter int DIV_LAT = 33
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ex_div,
   input  logic mem_stall,
   output logic div_start,
   output logic div_busy
);

   localparam int CW = $clog2(DIV_LAT);

   div_state_t     state;
   logic [CW-1:0]  cnt;

   assign div_start = rst_n && state == DIV_IDLE && ex_div && !mem_stall;
   assign div_busy  = div_start || (rst_n && state == DIV_BUSY && cnt != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= DIV_IDLE;
         cnt   <= '0;
      end else if (state == DIV_IDLE) begin
         if (div_start) begin
            state <= DIV_BUSY;
            cnt   <= CW'(DIV_LAT - 1);
         end
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end else if (!mem_stall) begin
         state <= DIV_IDLE;
      end
   end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: tracks EX and post-EX stage entries and derives stall, bubble, flush,
// operand forwarding and divider occupancy for a simple in-order pipeline.
module hazard_fwd_ctrl
   import hazard_fwd_ctrl_pkg::*;
#(
   parameter int NUM_FWD = 2,
   parameter int DIV_LAT = 33,
   parameter int RA_W    = 5
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           id_valid,
   input  logic                           id_rs1_used,
   input  logic                           id_rs2_used,
   input  logic                           id_rd_we,
   input  logic                           id_mem_to_reg,
   input  logic                           id_mem_acc,
   input  logic                           id_branch,
   input  logic                           id_is_div,
   input  logic [RA_W-1:0]                id_rs1_addr,
   input  logic [RA_W-1:0]                id_rs2_addr,
   input  logic [RA_W-1:0]                id_rd_addr,
   input  logic                           branch_taken,
   input  logic                           dmem_ready,
   output logic                           pc_en,
   output logic                           if_id_en,
   output logic                           id_ex_bubble,
   output logic                           if_id_flush,
   output logic [$clog2(NUM_FWD+1)-1:0]   fwd_a,
   output logic [$clog2(NUM_FWD+1)-1:0]   fwd_b,
   output logic                           br_fwd_a,
   output logic                           br_fwd_b,
   output logic                           div_start,
   output logic                           div_busy
);

   localparam int FW = $clog2(NUM_FWD + 1);

   ex_entry_t          ex, id_entry;
   dn_entry_t          dn [NUM_FWD];
   logic [RA_MAX-1:0]  rs1, rs2;
   logic               mem_stall, freeze, load_use, ex_hit, mem_hit, stall;

   assign rs1      = RA_MAX'(id_rs1_addr);
   assign rs2      = RA_MAX'(id_rs2_addr);
   assign id_entry = '{valid: id_valid, rs1: rs1, rs2: rs2, rd: RA_MAX'(id_rd_addr),
                       rd_we: id_rd_we, mem_to_reg: id_mem_to_reg, mem_acc: id_mem_acc,
                       is_div: id_is_div};

   assign mem_stall = dn[0].valid && dn[0].mem_acc && !dmem_ready;

   div_occupancy_fsm #(.DIV_LAT(DIV_LAT)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .ex_div    (ex.valid && ex.is_div),
      .mem_stall (mem_stall),
      .div_start (div_start),
      .div_busy  (div_busy)
   );

   assign freeze   = rst_n && (div_busy || mem_stall);
   assign load_use = ex.valid && ex.mem_to_reg && ex.rd != '0 &&
                     ((id_rs1_used && rs1 == ex.rd) || (id_rs2_used && rs2 == ex.rd));
   assign ex_hit   = ex.valid && ex.rd_we && ex.rd != '0 &&
                     ((id_rs1_used && rs1 == ex.rd) || (id_rs2_used && rs2 == ex.rd));
   assign mem_hit  = dn[0].valid && dn[0].mem_to_reg &&
                     ((id_rs1_used && rs1 == dn[0].rd) || (id_rs2_used && rs2 == dn[0].rd));
   assign stall    = rst_n && (load_use || (id_branch && (ex_hit || mem_hit)));

   assign pc_en        = !(freeze || stall);
   assign if_id_en     = pc_en;
   assign id_ex_bubble = stall && !freeze;
   assign if_id_flush  = rst_n && id_valid && id_branch && branch_taken && !freeze && !stall;
   assign br_fwd_a     = rst_n && writes(dn[0], rs1) && !dn[0].mem_to_reg;
   assign br_fwd_b     = rst_n && writes(dn[0], rs2) && !dn[0].mem_to_reg;

   // Walk from the oldest stage down so the youngest matching producer wins.
   always_comb begin
      fwd_a = FW'(FWD_RF);
      fwd_b = FW'(FWD_RF);
      if (rst_n)
         for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (writes(dn[k], ex.rs1)) fwd_a = FW'(k + FWD_MEM);
            if (writes(dn[k], ex.rs2)) fwd_b = FW'(k + FWD_MEM);
         end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex <= '0;
         for (int k = 0; k < NUM_FWD; k++) dn[k] <= '0;
      end else if (!freeze) begin
         ex    <= stall ? '0 : id_entry;
         dn[0] <= '{valid: ex.valid, rd: ex.rd, rd_we: ex.rd_we,
                    mem_to_reg: ex.mem_to_reg, mem_acc: ex.mem_acc};
         for (int k = 1; k < NUM_FWD; k++) dn[k] <= dn[k-1];
      end
   end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: directed scenarios plus randomized traffic against an instruction-level
// pipeline model that tracks each in-flight instruction and a divide's age in cycles.
module tb_hazard_fwd_ctrl;

   localparam int NF = 2;
   localparam int DL = 33;
   localparam int RW = 5;
   localparam int FW = $clog2(NF + 1);

   logic clk = 1'b0, rst_n = 1'b0;
   logic id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_mem_to_reg, id_mem_acc;
   logic id_branch, id_is_div, branch_taken, dmem_ready;
   logic [RW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic pc_en, if_id_en, id_ex_bubble, if_id_flush, br_fwd_a, br_fwd_b, div_start, div_busy;
   logic [FW-1:0] fwd_a, fwd_b;

   always #5 clk = ~clk;

   hazard_fwd_ctrl #(.NUM_FWD(NF), .DIV_LAT(DL), .RA_W(RW)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1_used(id_rs1_used),
      .id_rs2_used(id_rs2_used), .id_rd_we(id_rd_we), .id_mem_to_reg(id_mem_to_reg),
      .id_mem_acc(id_mem_acc), .id_branch(id_branch), .id_is_div(id_is_div),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
      .branch_taken(branch_taken), .dmem_ready(dmem_ready), .pc_en(pc_en), .if_id_en(if_id_en),
      .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .br_fwd_a(br_fwd_a), .br_fwd_b(br_fwd_b), .div_start(div_start), .div_busy(div_busy)
   );

   typedef struct {
      bit v;
      int rs1, rs2, rd;
      bit we, m2r, macc, dv;
   } ins_t;

   ins_t p [NF+1];
   int   age = -1;
   int   n_chk = 0, n_fail = 0;
   bit   m_frz, m_st, m_ds;
   int   nb, ns, bad, it;

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chkb(string nm, logic act, logic exp);
      chk(nm, int'(act), int'(exp));
   endtask

   function automatic bit uses(int a);
      return (id_rs1_used && int'(id_rs1_addr) == a) || (id_rs2_used && int'(id_rs2_addr) == a);
   endfunction

   task automatic eval;
      bit ms, db, lu, bs;
      int fa, fb;
      #1;
      ms   = p[1].v && p[1].macc && !dmem_ready;
      m_ds = rst_n && p[0].v && p[0].dv && age < 0 && !ms;
      db   = m_ds || (rst_n && age >= 1 && age < DL);
      m_frz = db || (rst_n && ms);
      lu   = p[0].v && p[0].m2r && p[0].rd != 0 && uses(p[0].rd);
      bs   = id_branch && ((p[0].v && p[0].we && p[0].rd != 0 && uses(p[0].rd)) ||
                           (p[1].v && p[1].m2r && uses(p[1].rd)));
      m_st = rst_n && (lu || bs);
      fa = 0;
      fb = 0;
      if (rst_n)
         for (int k = 1; k <= NF; k++) begin
            if (fa == 0 && p[k].v && p[k].we && p[k].rd != 0 && p[k].rd == p[0].rs1) fa = k;
            if (fb == 0 && p[k].v && p[k].we && p[k].rd != 0 && p[k].rd == p[0].rs2) fb = k;
         end
      chkb("pc_en", pc_en, !(m_frz || m_st));
      chkb("if_id_en", if_id_en, !(m_frz || m_st));
      chkb("id_ex_bubble", id_ex_bubble, m_st && !m_frz);
      chkb("if_id_flush", if_id_flush,
           rst_n && id_valid && id_branch && branch_taken && !m_frz && !m_st);
      chk("fwd_a", int'(fwd_a), fa);
      chk("fwd_b", int'(fwd_b), fb);
      chkb("br_fwd_a", br_fwd_a, rst_n && p[1].v && p[1].we && !p[1].m2r && p[1].rd != 0 &&
                                 p[1].rd == int'(id_rs1_addr));
      chkb("br_fwd_b", br_fwd_b, rst_n && p[1].v && p[1].we && !p[1].m2r && p[1].rd != 0 &&
                                 p[1].rd == int'(id_rs2_addr));
      chkb("div_start", div_start, m_ds);
      chkb("div_busy", div_busy, db);
   endtask

   task automatic adv;
      @(posedge clk);
      if (!rst_n) begin
         foreach (p[k]) p[k] = '{default: 0};
         age = -1;
      end else begin
         if (m_ds) age = 1;
         else if (age >= 1) age = m_frz ? age + 1 : -1;
         if (!m_frz) begin
            for (int k = NF; k >= 1; k--) p[k] = p[k-1];
            p[0] = '{default: 0};
            if (!m_st) begin
               p[0].v    = id_valid;
               p[0].rs1  = int'(id_rs1_addr);
               p[0].rs2  = int'(id_rs2_addr);
               p[0].rd   = int'(id_rd_addr);
               p[0].we   = id_rd_we;
               p[0].m2r  = id_mem_to_reg;
               p[0].macc = id_mem_acc;
               p[0].dv   = id_is_div;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic set_id(bit v, bit br, bit tk, bit u1, int a1, bit u2, int a2,
                         bit we, int rd, bit m2r, bit macc, bit dv);
      id_valid = v; id_branch = br; branch_taken = tk;
      id_rs1_used = u1; id_rs1_addr = RW'(a1);
      id_rs2_used = u2; id_rs2_addr = RW'(a2);
      id_rd_we = we; id_rd_addr = RW'(rd);
      id_mem_to_reg = m2r; id_mem_acc = macc; id_is_div = dv;
   endtask

   task automatic idle;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic drain;
      idle();
      repeat (3) begin eval(); adv(); end
   endtask

   initial begin
      idle();
      dmem_ready = 1'b1;
      @(negedge clk);
      eval(); chkb("rst_pc_en_during", pc_en, 1'b1); adv();
      eval(); adv();
      rst_n = 1'b1;
      eval();
      chkb("rst_pc_en", pc_en, 1'b1);
      chkb("rst_if_id_en", if_id_en, 1'b1);
      chkb("rst_div_busy", div_busy, 1'b0);
      chkb("rst_bubble", id_ex_bubble, 1'b0);
      adv();

      // add x5 then sub reading x5: forwarded from MEM with no stall
      drain();
      set_id(1, 0, 0, 1, 1, 1, 2, 1, 5, 0, 0, 0); eval(); adv();
      set_id(1, 0, 0, 1, 5, 1, 3, 1, 6, 0, 0, 0); eval();
      chkb("raw_no_stall", pc_en, 1'b1); adv();
      idle(); eval(); chk("raw_fwd_a_mem", int'(fwd_a), 1); adv();

      // load x7 then consumer: one bubble, then forwarded from WB
      set_id(1, 0, 0, 1, 1, 0, 0, 1, 7, 1, 1, 0); eval(); adv();
      set_id(1, 0, 0, 1, 7, 1, 2, 1, 8, 0, 0, 0); eval();
      chkb("lu_pc_en", pc_en, 1'b0); chkb("lu_bubble", id_ex_bubble, 1'b1); adv();
      eval(); chkb("lu_release", pc_en, 1'b1); chkb("lu_no_bubble", id_ex_bubble, 1'b0); adv();
      idle(); eval(); chk("lu_fwd_a_wb", int'(fwd_a), 2); adv();

      // divide behind a load, with a dmem_ready dip in the middle
      drain();
      set_id(1, 0, 0, 1, 1, 1, 2, 1, 9, 1, 1, 0); eval(); adv();
      set_id(1, 0, 0, 1, 1, 1, 2, 1, 10, 0, 0, 1); eval(); adv();
      idle(); eval();
      chkb("div_first_start", div_start, 1'b1);
      nb = 0; ns = 0; bad = 0; it = 0;
      while (div_busy && it < 100) begin
         nb++;
         ns  += int'(div_start);
         bad += int'(pc_en);
         adv();
         dmem_ready = (it != 10);
         it++;
         eval();
      end
      chkb("div_timeout", it < 100, 1'b1);
      chk("div_busy_cycles", nb, DL);
      chk("div_start_cycles", ns, 1);
      chk("div_pc_en_leak", bad, 0);
      chkb("div_release", pc_en, 1'b1);
      adv();

      // taken branch: immediate flush, then one withheld by a memory stall
      drain();
      set_id(1, 1, 1, 1, 1, 1, 2, 0, 0, 0, 0, 0); eval();
      chkb("flush_plain", if_id_flush, 1'b1); adv();
      set_id(1, 0, 0, 1, 1, 0, 0, 1, 11, 1, 1, 0); eval(); adv();
      idle(); eval(); adv();
      set_id(1, 1, 1, 1, 1, 1, 2, 0, 0, 0, 0, 0);
      dmem_ready = 1'b0;
      eval(); chkb("flush_withheld", if_id_flush, 1'b0); chkb("flush_frz_pc", pc_en, 1'b0); adv();
      dmem_ready = 1'b1;
      eval(); chkb("flush_after_stall", if_id_flush, 1'b1); adv();

      // x0 writers in MEM and WB never forward
      drain();
      set_id(1, 0, 0, 1, 1, 1, 2, 1, 0, 0, 0, 0); eval(); adv();
      eval(); adv();
      set_id(1, 0, 0, 1, 0, 1, 0, 1, 3, 0, 0, 0); eval(); adv();
      idle(); eval();
      chk("x0_fwd_a", int'(fwd_a), 0); chk("x0_fwd_b", int'(fwd_b), 0); adv();

      // reset in the middle of a divide
      drain();
      set_id(1, 0, 0, 1, 1, 1, 2, 1, 12, 0, 0, 1); eval(); adv();
      idle(); eval(); chkb("rdiv_start", div_start, 1'b1); adv();
      repeat (5) begin eval(); adv(); end
      eval(); chkb("rdiv_busy", div_busy, 1'b1);
      rst_n = 1'b0;
      eval(); adv();
      rst_n = 1'b1;
      eval(); chkb("rdiv_busy_cleared", div_busy, 1'b0); chkb("rdiv_pc_en", pc_en, 1'b1); adv();

      repeat (3000) begin
         rst_n = ($urandom_range(0, 399) != 0);
         set_id($urandom_range(0, 7) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0);
         dmem_ready = ($urandom_range(0, 3) != 0);
         eval();
         adv();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
